// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, state codes and width defaults for the EX-stage
// multiply/divide sequencer.
package muldiv_ctrl_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [2:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_BUSY = 2'd1,
    MD_ST_DONE = 2'd2
  } md_state_e;

  // Two's-complement magnitude; the most negative value maps to itself and
  // is then treated as unsigned.
  function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
    return x[MD_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_md_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module md_iter_step #(
  parameter int W = 32
) (
  input  logic         is_div_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] part_i,
  input  logic [W-1:0] opnd_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] part_o
);

  logic [W:0]   sum;
  logic [W:0]   mul_s;
  logic [W:0]   shifted;
  logic [W+1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, opnd_i};
    mul_s   = part_i[0] ? sum : {1'b0, acc_i};
    shifted = {acc_i, part_i[W-1]};
    // Extra top bit acts as the borrow of the trial subtraction.
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    acc_o   = acc_i;
    part_o  = part_i;
    if (is_div_i) begin
      if (!diff[W+1]) begin
        acc_o  = diff[W-1:0];
        part_o = {part_i[W-2:0], 1'b1};
      end else begin
        acc_o  = shifted[W-1:0];
        part_o = {part_i[W-2:0], 1'b0};
      end
    end else begin
      acc_o  = mul_s[W:1];
      part_o = {mul_s[0], part_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO register pair.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          md_op,
  input  logic [MD_WIDTH-1:0] rs_data,
  input  logic [MD_WIDTH-1:0] rt_data,
  input  logic                flush,
  output logic                mult_div_stall,
  output logic                mult_div_over,
  output logic [MD_WIDTH-1:0] hi,
  output logic [MD_WIDTH-1:0] lo,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int W = MD_WIDTH;

  // Flow-control contract: mult_div_stall is high from the issue cycle through
  // the last iteration; mult_div_over pulses for exactly one cycle once HI/LO
  // hold the result. A flush while busy drops stall without any over pulse.

  md_state_e          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       acc_q, acc_d, part_q, part_d, opnd_q, opnd_d;
  logic [W-1:0]       rs_raw_q, rs_raw_d, hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic               div0_q, div0_d;

  logic [W-1:0]   step_acc, step_part;
  logic [2*W-1:0] prod;
  logic           is_start, is_signed;

  md_iter_step #(.W(W)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .part_i   (part_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .part_o   (step_part)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    part_d         = part_q;
    opnd_d         = opnd_q;
    rs_raw_d       = rs_raw_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    is_div_d       = is_div_q;
    neg_d          = neg_q;
    rneg_d         = rneg_q;
    div0_d         = div0_q;
    mult_div_stall = 1'b0;
    mult_div_over  = 1'b0;
    prod           = {step_acc, step_part};
    is_start       = (md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU) ||
                     (md_op == MD_OP_DIV)  || (md_op == MD_OP_DIVU);
    is_signed      = (md_op == MD_OP_MULT) || (md_op == MD_OP_DIV);

    unique case (state_q)
      MD_ST_IDLE: begin
        if (!flush) begin
          if (is_start) begin
            mult_div_stall = 1'b1;
            is_div_d = (md_op == MD_OP_DIV) || (md_op == MD_OP_DIVU);
            neg_d    = is_signed && (rs_data[W-1] ^ rt_data[W-1]);
            rneg_d   = is_signed && rs_data[W-1];
            div0_d   = (rt_data == '0);
            rs_raw_d = rs_data;
            acc_d    = '0;
            cnt_d    = '0;
            // Multiply: part holds the multiplier; divide: part holds the dividend.
            if (is_div_d) begin
              part_d = is_signed ? md_abs(rs_data) : rs_data;
              opnd_d = is_signed ? md_abs(rt_data) : rt_data;
            end else begin
              part_d = is_signed ? md_abs(rt_data) : rt_data;
              opnd_d = is_signed ? md_abs(rs_data) : rs_data;
            end
            state_d = MD_ST_BUSY;
          end else if (md_op == MD_OP_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == MD_OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      MD_ST_BUSY: begin
        mult_div_stall = 1'b1;
        if (flush) begin
          state_d = MD_ST_IDLE;
        end else begin
          acc_d  = step_acc;
          part_d = step_part;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == MD_CNT_W'(W - 1)) begin
            state_d = MD_ST_DONE;
            if (!is_div_q) begin
              if (neg_q) prod = ~prod + 1'b1;
              hi_d = prod[2*W-1:W];
              lo_d = prod[W-1:0];
            end else if (div0_q) begin
              hi_d = rs_raw_q;
              lo_d = '1;
            end else begin
              lo_d = neg_q  ? (~step_part + 1'b1) : step_part;
              hi_d = rneg_q ? (~step_acc + 1'b1)  : step_acc;
            end
          end
        end
      end
      MD_ST_DONE: begin
        mult_div_over = 1'b1;
        state_d       = MD_ST_IDLE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      part_q   <= '0;
      opnd_q   <= '0;
      rs_raw_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      part_q   <= part_d;
      opnd_q   <= opnd_d;
      rs_raw_q <= rs_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == MD_ST_BUSY) || (state_q == MD_ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected {hi,lo} results.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk, reset, flush;
  logic [2:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        mult_div_stall, mult_div_over, busy;
  logic [31:0] hi, lo;
  logic [1:0]  state_dbg;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  int n_vec, n_err;

  muldiv_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .md_op          (md_op),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .flush          (flush),
    .mult_div_stall (mult_div_stall),
    .mult_div_over  (mult_div_over),
    .hi             (hi),
    .lo             (lo),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {hi, lo} from wide integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (op)
      3'd1: begin q = sa * sb; p = q; end
      3'd2: p = {32'd0, a} * {32'd0, b};
      3'd3, 3'd4: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          if (op == 3'd4) begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int lat, bad_stall;
    logic got;
    logic [63:0] e;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    md_op = op; rs_data = a; rt_data = b;
    #1;
    n_vec++;
    if (mult_div_stall !== 1'b1) begin
      n_err++; $display("FAIL %s issue_stall: got %b want 1", name, mult_div_stall);
    end
    lat = 0; got = 1'b0; bad_stall = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mult_div_over === 1'b1) got = 1'b1;
      else if (mult_div_stall !== 1'b1) bad_stall++;
    end
    n_vec++;
    if (!got || lat != 33 || bad_stall != 0) begin
      n_err++; $display("FAIL %s timing: over_seen=%b latency=%0d stall_gaps=%0d want latency 33 gaps 0", name, got, lat, bad_stall);
    end
    if (got) begin
      e = exp_q.pop_front();
      m_hi = e[63:32]; m_lo = e[31:0];
      n_vec++;
      if ({hi, lo} !== e) begin
        n_err++; $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
      end
      n_vec++;
      if (mult_div_stall !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL %s done_flags: stall=%b busy=%b want 0/1", name, mult_div_stall, busy);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    md_op = 3'd0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || mult_div_over !== 1'b0) begin
      n_err++; $display("FAIL %s back_idle: busy=%b over=%b want 0/0", name, busy, mult_div_over);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; md_op = 3'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (state_dbg !== MD_ST_IDLE || hi !== 32'd0 || lo !== 32'd0 ||
        mult_div_stall !== 1'b0 || mult_div_over !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_state: st=%0d hi=%h lo=%h stall=%b over=%b busy=%b want all 0",
                        state_dbg, hi, lo, mult_div_stall, mult_div_over, busy);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    issue_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    issue_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    issue_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mult_minint");
  endtask

  task automatic test_div();
    issue_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    issue_op(3'd4, 32'd100, 32'd7, "divu_100_7");
    issue_op(3'd3, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    issue_op(3'd4, 32'h1234_5678, 32'd0, "divu_by0");
    issue_op(3'd3, 32'hFFFF_FF00, 32'd0, "div_by0_neg");
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    md_op = 3'd5; rs_data = 32'hAAAA_5555;
    #1;
    n_vec++;
    if (mult_div_stall !== 1'b0) begin
      n_err++; $display("FAIL mthi_stall: got %b want 0", mult_div_stall);
    end
    @(negedge clk);
    m_hi = 32'hAAAA_5555;
    md_op = 3'd6; rs_data = 32'h0F0F_1234;
    n_vec++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      n_err++; $display("FAIL mthi_write: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", hi, lo, busy, m_hi, m_lo);
    end
    @(negedge clk);
    m_lo = 32'h0F0F_1234;
    md_op = 3'd5; rs_data = 32'h5555_5555; flush = 1'b1;
    n_vec++;
    if (lo !== m_lo || hi !== m_hi) begin
      n_err++; $display("FAIL mtlo_write: hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
    md_op = 3'd0; flush = 1'b0;
    n_vec++;
    if (hi !== m_hi) begin
      n_err++; $display("FAIL mthi_flushed: hi=%h want %h", hi, m_hi);
    end
  endtask

  task automatic test_flush();
    int over_seen;
    // Flush in IDLE suppresses the start.
    @(negedge clk);
    md_op = 3'd1; rs_data = 32'd5; rt_data = 32'd6; flush = 1'b1;
    #1;
    n_vec++;
    if (mult_div_stall !== 1'b0) begin
      n_err++; $display("FAIL idle_flush_stall: got %b want 0", mult_div_stall);
    end
    @(negedge clk);
    md_op = 3'd0; flush = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL idle_flush_busy: got %b want 0", busy);
    end
    // Flush at T+10 of a DIV.
    md_op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
    repeat (10) @(negedge clk);
    n_vec++;
    if (mult_div_stall !== 1'b1) begin
      n_err++; $display("FAIL busy_stall_t10: got %b want 1", mult_div_stall);
    end
    flush = 1'b1; md_op = 3'd0;
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (mult_div_stall !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL busy_flush: stall=%b busy=%b want 0/0", mult_div_stall, busy);
    end
    over_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mult_div_over !== 1'b0) over_seen++;
    end
    n_vec++;
    if (over_seen != 0 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL busy_flush_result: over_cycles=%0d hi=%h lo=%h want 0 hi=%h lo=%h",
                        over_seen, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    md_op = 3'd2; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1234_5678;
    repeat (20) @(negedge clk);
    reset = 1'b1; md_op = 3'd0;
    @(negedge clk);
    n_vec++;
    if (state_dbg !== MD_ST_IDLE || hi !== 32'd0 || lo !== 32'd0 ||
        mult_div_stall !== 1'b0 || mult_div_over !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_op: st=%0d hi=%h lo=%h stall=%b over=%b busy=%b want all 0",
                        state_dbg, hi, lo, mult_div_stall, mult_div_over, busy);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    issue_op(3'd1, 32'd5, 32'hFFFF_FFFD, "mult_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue_op(op, a, b, "random");
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
